// File: rtl/mem_access_unit_pkg.sv
// Shared RV32 load/store encodings, FSM states and store lane formatting
// for the memory-stage access unit and its load aligner.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mau_state_t;

    typedef struct packed {
        logic [3:0]  byte_en;
        logic [31:0] wdata;
    } store_fmt_t;

    function automatic logic is_access_fault(
        input logic       is_read,
        input logic [2:0] func3,
        input logic [1:0] addr_lo
    );
        logic fault;
        case (func3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = addr_lo[0];
            F3_W:    fault = |addr_lo;
            // Unsigned size codes only exist for loads.
            F3_BU:   fault = !is_read;
            F3_HU:   fault = !is_read || addr_lo[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

    function automatic store_fmt_t format_store(
        input logic [2:0]  func3,
        input logic [1:0]  addr_lo,
        input logic [31:0] data
    );
        store_fmt_t fmt;
        case (func3)
            F3_B: begin
                fmt.byte_en = 4'b0001 << addr_lo;
                fmt.wdata   = {4{data[7:0]}};
            end
            F3_H: begin
                fmt.byte_en = 4'b0011 << {addr_lo[1], 1'b0};
                fmt.wdata   = {2{data[15:0]}};
            end
            default: begin
                fmt.byte_en = 4'b1111;
                fmt.wdata   = data;
            end
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load lane select and sign/zero extension; kept standalone so
// a load-forwarding path can reuse it.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_func3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns EX/MEM requests into byte-enabled word
// accesses with a fixed-latency stall handshake and formats load results.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req_valid,
    input  logic        Mem_read,
    input  logic        Mem_write,
    input  logic [2:0]  Func3,
    input  logic [31:0] Address,
    input  logic [31:0] Store_data,
    input  logic [4:0]  Rd_in,
    output logic        Dmem_read,
    output logic        Dmem_write,
    output logic [31:0] Dmem_addr,
    output logic [31:0] Dmem_wdata,
    output logic [3:0]  Dmem_byte_en,
    input  logic [31:0] Dmem_rdata,
    output logic        Stall,
    output logic        Load_valid,
    output logic [31:0] Load_data,
    output logic [4:0]  Rd_out,
    output logic        Access_fault
);

    mau_state_t       r_state;
    mau_state_t       w_state_next;
    logic [CNT_W-1:0] r_count;

    logic        r_dmem_read;
    logic        r_dmem_write;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_byte_en;
    logic [1:0]  r_offset;
    logic [2:0]  r_func3;
    logic [4:0]  r_rd;
    logic        r_load_valid;
    logic [31:0] r_load_data;
    logic [4:0]  r_rd_out;
    logic        r_access_fault;

    logic        w_request;
    logic        w_is_read;
    logic        w_fault;
    logic        w_accept;
    logic        w_last;
    store_fmt_t  w_store;
    logic [31:0] w_aligned;

    // Read wins when both strobes are set.
    assign w_request = Req_valid && (Mem_read || Mem_write);
    assign w_is_read = Mem_read;
    assign w_fault   = is_access_fault(w_is_read, Func3, Address[1:0]);
    assign w_store   = format_store(Func3, Address[1:0], Store_data);

    load_align u_load_align (
        .i_func3  (r_func3),
        .i_offset (r_offset),
        .i_rdata  (Dmem_rdata),
        .o_data   (w_aligned)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        w_state_next = r_state;
        Stall        = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_request && !w_fault) begin
                    w_accept     = 1'b1;
                    Stall        = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (r_count == CNT_W'(1)) begin
                    w_last       = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= CNT_W'(MEM_LATENCY);
        end else if (r_state == BUSY) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_byte_en <= '0;
            r_offset       <= '0;
            r_func3        <= '0;
            r_rd           <= '0;
            r_load_valid   <= 1'b0;
            r_load_data    <= '0;
            r_rd_out       <= '0;
            r_access_fault <= 1'b0;
        end else begin
            r_access_fault <= (r_state == IDLE) && w_request && w_fault;
            r_load_valid   <= 1'b0;

            if (w_accept) begin
                r_dmem_read    <= w_is_read;
                r_dmem_write   <= !w_is_read;
                r_dmem_addr    <= {Address[31:2], 2'b00};
                r_dmem_byte_en <= w_is_read ? 4'b1111 : w_store.byte_en;
                r_offset       <= Address[1:0];
                r_func3        <= Func3;
                r_rd           <= Rd_in;
                if (!w_is_read) begin
                    r_dmem_wdata <= w_store.wdata;
                end
            end

            // Read data is valid in the last latency cycle; register it for the RESP slot.
            if (w_last) begin
                r_dmem_read  <= 1'b0;
                r_dmem_write <= 1'b0;
                if (r_dmem_read) begin
                    r_load_valid <= 1'b1;
                    r_load_data  <= w_aligned;
                    r_rd_out     <= r_rd;
                end
            end
        end
    end

    assign Dmem_read    = r_dmem_read;
    assign Dmem_write   = r_dmem_write;
    assign Dmem_addr    = r_dmem_addr;
    assign Dmem_wdata   = r_dmem_wdata;
    assign Dmem_byte_en = r_dmem_byte_en;
    assign Load_valid   = r_load_valid;
    assign Load_data    = r_load_data;
    assign Rd_out       = r_rd_out;
    assign Access_fault = r_access_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a cycle-indexed behavioural model
// feeds expected outputs to one compare process, plus directed literal checks.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int L = 2;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req_valid, Mem_read, Mem_write;
    logic [2:0]  Func3;
    logic [31:0] Address, Store_data, Dmem_rdata;
    logic [4:0]  Rd_in;
    logic        Dmem_read, Dmem_write, Stall, Load_valid, Access_fault;
    logic [31:0] Dmem_addr, Dmem_wdata, Load_data;
    logic [3:0]  Dmem_byte_en;
    logic [4:0]  Rd_out;

    mem_access_unit #(.MEM_LATENCY(L), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .Req_valid(Req_valid), .Mem_read(Mem_read),
        .Mem_write(Mem_write), .Func3(Func3), .Address(Address), .Store_data(Store_data),
        .Rd_in(Rd_in), .Dmem_read(Dmem_read), .Dmem_write(Dmem_write), .Dmem_addr(Dmem_addr),
        .Dmem_wdata(Dmem_wdata), .Dmem_byte_en(Dmem_byte_en), .Dmem_rdata(Dmem_rdata),
        .Stall(Stall), .Load_valid(Load_valid), .Load_data(Load_data), .Rd_out(Rd_out),
        .Access_fault(Access_fault)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        bit        stall, rd, wr, lv, fault;
        bit [31:0] addr, wdata;
        bit [3:0]  be;
        bit [31:0] ld;
        bit [4:0]  rdo;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl_ld;
    logic [4:0]  mdl_rd;

    // Observation counters used by the directed checks.
    int          stall_cnt, wr_cnt, rd_cnt, lv_cnt, fault_cnt;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;

    always @(negedge Clock) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("stall", Stall, e.stall);
            check("dmem_read", Dmem_read, e.rd);
            check("dmem_write", Dmem_write, e.wr);
            check("load_valid", Load_valid, e.lv);
            check("access_fault", Access_fault, e.fault);
            check("load_data", Load_data, e.ld);
            check("rd_out", Rd_out, e.rdo);
            if (e.rd || e.wr) begin
                check("dmem_addr", Dmem_addr, e.addr);
                check("dmem_byte_en", Dmem_byte_en, e.be);
                if (e.wr) check("dmem_wdata", Dmem_wdata, e.wdata);
            end
        end
        if (Stall) stall_cnt++;
        if (Dmem_write) wr_cnt++;
        if (Dmem_read) rd_cnt++;
        if (Load_valid) lv_cnt++;
        if (Access_fault) fault_cnt++;
        if (Dmem_read || Dmem_write) begin
            seen_addr  = Dmem_addr;
            seen_wdata = Dmem_wdata;
            seen_be    = Dmem_byte_en;
        end
    end

    function automatic logic [31:0] load_model(int size, bit sgn, int off, logic [31:0] rdata);
        int unsigned v;
        if (size == 4) return rdata;
        v = rdata >> (8 * off);
        v = v % (32'd1 << (8 * size));
        if (sgn && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
        return v;
    endfunction

    task automatic clear_obs();
        stall_cnt = 0; wr_cnt = 0; rd_cnt = 0; lv_cnt = 0; fault_cnt = 0;
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input logic [4:0] rdi);
        bit   req   = rd || wr;
        bit   legal = 1'b1;
        int   size  = 4;
        bit   sgn   = 1'b0;
        int   off   = int'(addr[1:0]);
        int   n;
        exp_t e;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: if (rd) size = 1; else legal = 1'b0;
            3'd5: if (rd) size = 2; else legal = 1'b0;
            default: legal = 1'b0;
        endcase
        if (legal && (off % size) != 0) legal = 1'b0;
        n = !req ? 1 : (legal ? L + 2 : 2);
        for (int k = 0; k < n; k++) begin
            @(posedge Clock);
            #1;
            Req_valid  = (req && legal) ? 1'b1 : (k == 0);
            Mem_read   = rd;
            Mem_write  = wr;
            Func3      = f3;
            Address    = addr;
            Store_data = sdata;
            Rd_in      = rdi;
            Dmem_rdata = (k == L) ? rdata : $urandom;
            e     = '0;
            e.ld  = mdl_ld;
            e.rdo = mdl_rd;
            if (req && legal) begin
                e.stall = (k <= L);
                if (k >= 1 && k <= L) begin
                    e.rd   = rd;
                    e.wr   = !rd;
                    e.addr = addr & 32'hFFFF_FFFC;
                    if (rd) e.be = 4'hF;
                    else begin
                        e.be = 4'(((1 << size) - 1) << off);
                        e.wdata = (size == 1) ? sdata[7:0] * 32'h0101_0101 :
                                  (size == 2) ? sdata[15:0] * 32'h0001_0001 : sdata;
                    end
                end
                if (k == L + 1 && rd) begin
                    mdl_ld = load_model(size, sgn, off, rdata);
                    mdl_rd = rdi;
                    e.lv   = 1'b1;
                    e.ld   = mdl_ld;
                    e.rdo  = mdl_rd;
                end
            end else if (req) begin
                e.fault = (k == 1);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge Clock);
            #1;
            Req_valid  = 1'($urandom_range(0, 1));
            Mem_read   = 1'b0;
            Mem_write  = 1'b0;
            Func3      = 3'($urandom_range(0, 7));
            Address    = $urandom;
            Store_data = $urandom;
            Rd_in      = 5'($urandom_range(0, 31));
            Dmem_rdata = $urandom;
            e     = '0;
            e.ld  = mdl_ld;
            e.rdo = mdl_rd;
            exp_q.push_back(e);
        end
    endtask

    task automatic settle();
        @(negedge Clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; Req_valid = 1'b0; Mem_read = 1'b0; Mem_write = 1'b0;
        Func3 = '0; Address = '0; Store_data = '0; Rd_in = '0; Dmem_rdata = '0;
        mdl_ld = '0; mdl_rd = '0;
        clear_obs();
        #1 Reset = 1'b1;
        #1;
        check("rst_dmem_read", Dmem_read, 0);
        check("rst_dmem_write", Dmem_write, 0);
        check("rst_dmem_addr", Dmem_addr, 0);
        check("rst_dmem_wdata", Dmem_wdata, 0);
        check("rst_byte_en", Dmem_byte_en, 0);
        check("rst_load_data", Load_data, 0);
        check("rst_rd_out", Rd_out, 0);
        check("rst_load_valid", Load_valid, 0);
        check("rst_fault", Access_fault, 0);
        check("rst_stall", Stall, 0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        idle(2);

        // SW, latency 2: three stall cycles, two write cycles.
        settle(); clear_obs();
        do_access(1'b0, 1'b1, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 5'd0);
        settle();
        check("sw_stall_cycles", stall_cnt, 3);
        check("sw_write_cycles", wr_cnt, 2);
        check("sw_addr", seen_addr, 32'h104);
        check("sw_be", seen_be, 4'b1111);
        check("sw_wdata", seen_wdata, 32'hDEADBEEF);
        check("sw_no_load_valid", lv_cnt, 0);

        do_access(1'b0, 1'b1, F3_B, 32'h103, 32'h000000A5, 32'h0, 5'd0);
        settle();
        check("sb_addr", seen_addr, 32'h100);
        check("sb_be", seen_be, 4'b1000);
        check("sb_wdata", seen_wdata, 32'hA5A5A5A5);

        clear_obs();
        do_access(1'b1, 1'b0, F3_B, 32'h101, 32'h0, 32'h12348056, 5'd7);
        settle();
        check("lb_data", Load_data, 32'hFFFFFF80);
        check("lb_rd", Rd_out, 5'd7);
        check("lb_pulses", lv_cnt, 1);
        do_access(1'b1, 1'b0, F3_BU, 32'h101, 32'h0, 32'h12348056, 5'd7);
        settle();
        check("lbu_data", Load_data, 32'h00000080);
        do_access(1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h80010000, 5'd3);
        settle();
        check("lh_data", Load_data, 32'hFFFF8001);
        do_access(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h80010000, 5'd3);
        settle();
        check("lhu_data", Load_data, 32'h00008001);

        // Back-to-back loads with no idle cycle between them.
        do_access(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 32'hCAFEF00D, 5'd11);
        do_access(1'b1, 1'b1, F3_W, 32'h204, 32'h0, 32'h0BADC0DE, 5'd12);
        settle();
        check("b2b_data", Load_data, 32'h0BADC0DE);
        check("b2b_rd", Rd_out, 5'd12);

        clear_obs();
        do_access(1'b1, 1'b0, F3_W, 32'h102, 32'h0, 32'h0, 5'd1);
        do_access(1'b0, 1'b1, 3'b011, 32'h100, 32'h1234, 32'h0, 5'd0);
        settle();
        check("fault_pulses", fault_cnt, 2);
        check("fault_strobes", rd_cnt + wr_cnt, 0);
        check("fault_stall", stall_cnt, 0);

        // Reset during BUSY of an LW abandons it asynchronously.
        idle(1);
        settle(); clear_obs();
        @(posedge Clock); #1;
        Req_valid = 1'b1; Mem_read = 1'b1; Mem_write = 1'b0; Func3 = F3_W;
        Address = 32'h300; Rd_in = 5'd9;
        @(posedge Clock); #1;
        check("rst_mid_pre_read", Dmem_read, 1);
        #2;
        Reset = 1'b1; Req_valid = 1'b0; Mem_read = 1'b0;
        #1;
        check("rst_mid_read", Dmem_read, 0);
        check("rst_mid_addr", Dmem_addr, 0);
        check("rst_mid_stall", Stall, 0);
        check("rst_mid_load_data", Load_data, 0);
        @(posedge Clock); #1;
        Reset  = 1'b0;
        mdl_ld = '0;
        mdl_rd = '0;
        idle(3);
        settle();
        check("rst_mid_no_lv", lv_cnt, 0);
        do_access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'h55AA1234, 5'd9);
        settle();
        check("post_rst_lw", Load_data, 32'h55AA1234);
        check("post_rst_rd", Rd_out, 5'd9);

        for (int i = 0; i < 300; i++) begin
            bit          rd, wr;
            logic [31:0] addr;
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            do_access(rd, wr, 3'($urandom_range(0, 7)), addr, $urandom, $urandom,
                      5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        settle();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
